// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: shares the single data-memory/peripheral bus between the
// core LSU (requester 0) and the debug/program-loader port (requester 1).
// One transaction is in flight at a time: IDLE -> REQ -> (RSP) -> CMPL -> IDLE.
// A response timeout finishes a stuck transaction with an error so the core
// never hangs on a dead peripheral.
module lsu_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  // core requester
  input  logic                i_c_valid,
  input  logic                i_c_we,
  input  logic [ADDR_W-1:0]   i_c_addr,
  input  logic [DATA_W-1:0]   i_c_wdata,
  input  logic [DATA_W/8-1:0] i_c_be,
  output logic                o_c_ready,
  output logic [DATA_W-1:0]   o_c_rdata,
  output logic                o_c_err,
  // debug requester
  input  logic                i_d_valid,
  input  logic                i_d_we,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_be,
  output logic                o_d_ready,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_d_err,
  // memory bus
  output logic                o_m_req,
  output logic                o_m_we,
  output logic [ADDR_W-1:0]   o_m_addr,
  output logic [DATA_W-1:0]   o_m_wdata,
  output logic [DATA_W/8-1:0] o_m_be,
  input  logic                i_m_gnt,
  input  logic                i_m_rvalid,
  input  logic [DATA_W-1:0]   i_m_rdata,
  output logic                o_busy
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_CMPL} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 0 = core, 1 = debug
  logic                last_q, last_d;     // last winner, same encoding
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                any_valid;
  logic                pick_dbg;
  logic                rsp_done;
  logic                to_hit;
  logic [DATA_W-1:0]   cmpl_data;

  // Debug wins when it is alone, or on a tie when core was served last.
  assign any_valid = i_c_valid | i_d_valid;
  assign pick_dbg  = i_d_valid & (~i_c_valid | ~last_q);

  // Completion beats timeout; rvalid without gnt in REQ does not complete.
  assign rsp_done  = ((state_q == S_REQ) & i_m_gnt & i_m_rvalid) |
                     ((state_q == S_RSP) & i_m_rvalid);
  assign to_hit    = ((state_q == S_REQ) | (state_q == S_RSP)) & (cnt_q == TO_LAST);
  assign cmpl_data = (rsp_done & ~we_q) ? i_m_rdata : '0;

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (any_valid) state_d = S_REQ;
      S_REQ: begin
        if (i_m_gnt && i_m_rvalid) state_d = S_CMPL;
        else if (to_hit)           state_d = S_CMPL;
        else if (i_m_gnt)          state_d = S_RSP;
      end
      S_RSP:  if (i_m_rvalid || to_hit) state_d = S_CMPL;
      S_CMPL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant/payload capture, timeout counting and response latching.
  always_comb begin
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          owner_d = pick_dbg;
          last_d  = pick_dbg;
          cnt_d   = '0;
          err_d   = 1'b0;
          if (pick_dbg) begin
            we_d    = i_d_we;
            addr_d  = i_d_addr;
            wdata_d = i_d_wdata;
            be_d    = i_d_be;
          end else begin
            we_d    = i_c_we;
            addr_d  = i_c_addr;
            wdata_d = i_c_wdata;
            be_d    = i_c_be;
          end
        end
      end
      S_REQ, S_RSP: begin
        cnt_d = cnt_q + 1'b1;
        if (rsp_done || to_hit) begin
          err_d = ~rsp_done;
          if (owner_q) d_rdata_d = cmpl_data;
          else         c_rdata_d = cmpl_data;
        end
      end
      default: ;
    endcase
  end

  // Bus and requester outputs decoded from the registered state.
  always_comb begin
    o_m_req   = (state_q == S_REQ);
    o_m_we    = we_q;
    o_m_addr  = addr_q;
    o_m_wdata = wdata_q;
    o_m_be    = be_q;
    o_busy    = (state_q != S_IDLE);
    o_c_ready = (state_q == S_CMPL) & ~owner_q;
    o_d_ready = (state_q == S_CMPL) & owner_q;
    o_c_err   = o_c_ready & err_q;
    o_d_err   = o_d_ready & err_q;
    o_c_rdata = c_rdata_q;
    o_d_rdata = d_rdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: table of single transactions against a scripted
// memory, plus hand-written sequences for arbitration, reset and idle noise.
module tb_lsu_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              c_valid = 0, c_we = 0, d_valid = 0, d_we = 0;
  logic [ADDR_W-1:0] c_addr = '0, d_addr = '0;
  logic [DATA_W-1:0] c_wdata = '0, d_wdata = '0;
  logic [3:0]        c_be = '0, d_be = '0;
  logic              c_ready, c_err, d_ready, d_err;
  logic [DATA_W-1:0] c_rdata, d_rdata;
  logic              m_req, m_we, m_gnt = 0, m_rvalid = 0, busy;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata = '0;
  logic [3:0]        m_be;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          src;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gnt_cyc;
    int          rv_cyc;
    bit          spur;
    bit          late;
    logic [31:0] mem_rdata;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  logic [31:0] last_c = '0;
  logic [31:0] last_d = '0;

  lsu_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c_valid(c_valid), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata), .i_c_be(c_be),
    .o_c_ready(c_ready), .o_c_rdata(c_rdata), .o_c_err(c_err),
    .i_d_valid(d_valid), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_be(d_be),
    .o_d_ready(d_ready), .o_d_rdata(d_rdata), .o_d_err(d_err),
    .o_m_req(m_req), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata), .o_m_be(m_be),
    .i_m_gnt(m_gnt), .i_m_rvalid(m_rvalid), .i_m_rdata(m_rdata),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard on any ready pulse and checks the quiet side too.
  task automatic monitor(input int cyc);
    exp_t e;
    chk("both_ready", {c_ready, d_ready} == 2'b11, 0);
    if (c_ready || d_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_ready", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("ready_port", d_ready, e.port);
        chk("ready_cycle", cyc, e.cyc);
        chk("rsp_rdata", e.port ? d_rdata : c_rdata, e.rdata);
        chk("rsp_err", e.port ? d_err : c_err, e.err);
        if (e.port) last_d = e.rdata;
        else        last_c = e.rdata;
      end
    end
    if (!c_ready) begin
      chk("c_err_idle", c_err, 0);
      chk("c_rdata_hold", c_rdata, last_c);
    end
    if (!d_ready) begin
      chk("d_err_idle", d_err, 0);
      chk("d_rdata_hold", d_rdata, last_d);
    end
  endtask

  task automatic flush_sb();
    while (sb.size() != 0) begin
      void'(sb.pop_front());
      chk("missing_ready", 1, 0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   req_end;
    req_end = (v.gnt_cyc < v.exp_cyc) ? v.gnt_cyc : v.exp_cyc - 1;
    e.port = v.src; e.rdata = v.exp_rdata; e.err = v.exp_err; e.cyc = v.exp_cyc;
    sb.push_back(e);
    for (int cyc = 0; cyc <= v.exp_cyc + 2; cyc++) begin
      monitor(cyc);
      chk("busy", busy, (cyc >= 1) && (cyc <= v.exp_cyc));
      chk("m_req", m_req, (cyc >= 1) && (cyc <= req_end));
      if (cyc >= 1 && cyc <= req_end) begin
        chk("m_we", m_we, v.we);
        chk("m_addr", m_addr, v.addr);
        chk("m_wdata", m_wdata, v.wdata);
        chk("m_be", m_be, v.be);
      end
      // requester side
      if (cyc == 0) begin
        if (v.src) begin
          d_valid = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end else begin
          c_valid = 1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata; c_be = v.be;
        end
      end else begin
        c_addr = ~c_addr; c_wdata = $urandom; c_be = ~c_be; c_we = ~c_we;
        d_addr = ~d_addr; d_wdata = $urandom; d_be = ~d_be; d_we = ~d_we;
      end
      if (c_ready) c_valid = 0;
      if (d_ready) d_valid = 0;
      // memory side
      m_gnt    = (cyc == v.gnt_cyc);
      m_rvalid = (cyc == v.rv_cyc) || (v.spur && cyc == 1) || (v.late && cyc == v.exp_cyc + 1);
      m_rdata  = (cyc == v.rv_cyc) ? v.mem_rdata : $urandom;
      step();
    end
    m_gnt = 0; m_rvalid = 0; c_valid = 0; d_valid = 0;
    flush_sb();
  endtask

  vec_t vecs[8];

  initial begin
    exp_t e;
    // src we addr wdata be gnt rv spur late mem exp_cyc exp_rdata exp_err
    vecs[0] = '{0, 0, 32'h200, 32'h0, 4'hF, 1, 3, 0, 0, 32'hDEADBEEF, 4, 32'hDEADBEEF, 0};
    vecs[1] = '{0, 1, 32'h100, 32'h1234, 4'b0011, 4, 5, 0, 0, 32'hFFFFFFFF, 6, 32'h0, 0};
    vecs[2] = '{1, 0, 32'h3000, 32'h0, 4'hF, 1, 1, 0, 0, 32'hA5A50001, 2, 32'hA5A50001, 0};
    vecs[3] = '{1, 1, 32'h44, 32'hCAFEF00D, 4'b1100, 2, 2, 0, 0, 32'h12345678, 3, 32'h0, 0};
    vecs[4] = '{0, 0, 32'h400, 32'h0, 4'hF, 1, -1, 0, 1, 32'h0, 17, 32'h0, 1};
    vecs[5] = '{1, 0, 32'h500, 32'h0, 4'hF, 100, -1, 0, 0, 32'h0, 17, 32'h0, 1};
    vecs[6] = '{0, 0, 32'h600, 32'h0, 4'hF, 1, 16, 0, 0, 32'h600DF00D, 17, 32'h600DF00D, 0};
    vecs[7] = '{0, 0, 32'h700, 32'h0, 4'hF, 3, 4, 1, 0, 32'h77778888, 5, 32'h77778888, 0};

    // reset state
    step(); step();
    chk("rst_m_req", m_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {c_ready, d_ready}, 0);
    chk("rst_rdata", {c_rdata, d_rdata}, 0);
    chk("rst_m_addr", m_addr, 0);
    rst_n = 1;

    // both valid after reset, zero-latency memory: core first, then alternate
    e = '{0, 32'hCAFE0010, 0, 2};  sb.push_back(e);
    e = '{1, 32'hCAFE0020, 0, 5};  sb.push_back(e);
    e = '{0, 32'hCAFE0010, 0, 8};  sb.push_back(e);
    e = '{1, 32'hCAFE0020, 0, 11}; sb.push_back(e);
    c_we = 0; c_addr = 32'h10; c_be = 4'hF;
    d_we = 0; d_addr = 32'h20; d_be = 4'hF;
    for (int cyc = 0; cyc <= 13; cyc++) begin
      monitor(cyc);
      c_valid  = (cyc <= 11) && !c_ready;
      d_valid  = (cyc <= 11) && !d_ready;
      m_gnt    = m_req;
      m_rvalid = m_req;
      m_rdata  = m_addr ^ 32'hCAFE0000;
      step();
    end
    chk("rr_idle_busy", busy, 0);
    m_gnt = 0; m_rvalid = 0; c_valid = 0; d_valid = 0;
    flush_sb();

    // single-transaction table
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // reset in the middle of an RSP wait
    c_valid = 1; c_we = 0; c_addr = 32'h800; c_be = 4'hF; c_wdata = '0;
    step();               // cycle 1: REQ
    m_gnt = 1;
    step();               // cycle 2: RSP
    m_gnt = 0;
    step();               // cycle 3
    chk("mid_busy_before", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_m_req", m_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", {c_ready, d_ready}, 0);
    chk("mid_rst_rdata", {c_rdata, d_rdata}, 0);
    chk("mid_rst_m_addr", m_addr, 0);
    last_c = '0; last_d = '0;
    step();               // cycle 4: released, IDLE
    rst_n = 1;
    e = '{0, 32'h00005EED, 0, 6}; sb.push_back(e);
    monitor(4);
    chk("rel_m_req_c4", m_req, 0);
    step();               // cycle 5: request re-issued
    monitor(5);
    chk("rel_m_req_c5", m_req, 1);
    chk("rel_m_addr", m_addr, 32'h800);
    m_gnt = 1; m_rvalid = 1; m_rdata = 32'h5EED;
    step();               // cycle 6: CMPL
    m_gnt = 0; m_rvalid = 0;
    monitor(6);
    c_valid = 0;
    step();
    monitor(7);
    chk("rel_idle", busy, 0);
    flush_sb();

    // spurious rvalid while idle
    for (int cyc = 0; cyc < 4; cyc++) begin
      m_rvalid = 1; m_rdata = $urandom;
      step();
      monitor(cyc);
      chk("spur_idle_busy", busy, 0);
    end
    m_rvalid = 0;
    flush_sb();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
